// File: rtl/aes_pkg.sv
// Shared AES definitions: the S-box table, word/round-key types, the
// expander state encoding and the GF(2^8) helper functions.
package aes_pkg;

    localparam int NUM_ROUNDS_AES128 = 10;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] round_key_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } expander_sm_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

endpackage

// File: rtl/dvr_if.sv
// Data/valid/ready handshake: a transfer happens on a clock edge where
// both valid and ready are high.
interface dvr_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in and one byte out; shared with
// the encrypter's SubBytes stage.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_key_expander.sv
// AES-128 key expander: accepts a cipher key over dvr_if and produces one
// round key per clock into an 11-entry register file read by index.
module aes_key_expander
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_WIDTH  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    dvr_if.slave                 key_in,
    input  logic [3:0]           rd_idx,
    output logic [KEY_WIDTH-1:0] rd_key,
    output logic                 keys_valid,
    output logic                 busy
);

    if (NUM_ROUNDS != NUM_ROUNDS_AES128) begin : g_bad_rounds
        $error("aes_key_expander supports only NUM_ROUNDS = 10");
    end
    if (KEY_WIDTH != 128) begin : g_bad_width
        $error("aes_key_expander supports only KEY_WIDTH = 128");
    end

    expander_sm_t state_q, state_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    round_key_t   w_q, w_d;
    round_key_t   rk_q [NUM_ROUNDS+1];
    round_key_t   rk_d [NUM_ROUNDS+1];
    logic         keys_valid_q, keys_valid_d;

    word_t      rot_w3;
    word_t      sub_rot;
    word_t      temp;
    word_t      nw0, nw1, nw2, nw3;
    round_key_t next_rk;
    logic       accept;

    // SubWord(RotWord(w3)) via four S-box lookups on the rotated last word.
    assign rot_w3 = {w_q[23:0], w_q[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (rot_w3[8*b +: 8]),
            .out_byte (sub_rot[8*b +: 8])
        );
    end

    assign temp    = sub_rot ^ {rcon_q, 24'h0};
    assign nw0     = w_q[127:96] ^ temp;
    assign nw1     = w_q[95:64]  ^ nw0;
    assign nw2     = w_q[63:32]  ^ nw1;
    assign nw3     = w_q[31:0]   ^ nw2;
    assign next_rk = {nw0, nw1, nw2, nw3};

    assign key_in.ready = (state_q != EXPAND);
    assign accept       = key_in.valid && key_in.ready;
    assign keys_valid   = keys_valid_q;
    assign busy         = (state_q == EXPAND);

    always_comb begin
        state_d      = state_q;
        rcon_d       = rcon_q;
        cnt_d        = cnt_q;
        w_d          = w_q;
        keys_valid_d = keys_valid_q;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk_d[i] = rk_q[i];
        end

        case (state_q)
            IDLE, DONE: begin
                // Accepting from DONE drops keys_valid at the same edge.
                if (accept) begin
                    rk_d[0]      = key_in.data;
                    w_d          = key_in.data;
                    cnt_d        = 4'd1;
                    rcon_d       = 8'h01;
                    keys_valid_d = 1'b0;
                    state_d      = EXPAND;
                end
            end
            EXPAND: begin
                for (int i = 1; i <= NUM_ROUNDS; i++) begin
                    if (cnt_q == 4'(i)) begin
                        rk_d[i] = next_rk;
                    end
                end
                w_d    = next_rk;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(NUM_ROUNDS)) begin
                    keys_valid_d = 1'b1;
                    state_d      = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rcon_q       <= 8'h01;
            cnt_q        <= 4'd0;
            w_q          <= '0;
            keys_valid_q <= 1'b0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            rcon_q       <= rcon_d;
            cnt_q        <= cnt_d;
            w_q          <= w_d;
            keys_valid_q <= keys_valid_d;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_q[i] <= rk_d[i];
            end
        end
    end

    // Indices beyond the last round key read as zero.
    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_key = rk_q[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander: FIPS-197 vectors plus random keys
// against a GF(2^8)-arithmetic reference schedule.
module tb_aes_key_expander;

    logic         clk;
    logic         rst;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;
    logic         keys_valid;
    logic         busy;

    int checks = 0;
    int errors = 0;

    logic [127:0] model_rk [11];

    dvr_if #(.DATA_W(128)) key_if ();

    aes_key_expander #(
        .NUM_ROUNDS (10),
        .KEY_WIDTH  (128)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_in     (key_if),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key),
        .keys_valid (keys_valid),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] v);
        logic [7:0] inv = 8'h01;
        logic [7:0] s;
        if (v == 8'h00) inv = 8'h00;
        else for (int i = 0; i < 254; i++) inv = gmul(inv, v);
        s = 8'h63;
        for (int r = 0; r < 5; r++) begin
            s = s ^ ((inv << r) | (inv >> (8 - r)));
        end
        return s;
    endfunction

    task automatic buildModel(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a key at a falling edge; returns just after the handshake edge.
    task automatic applyStimulus(input string tag, input logic [127:0] key);
        @(negedge clk);
        key_if.data  = key;
        key_if.valid = 1'b1;
        checkOutput({tag, "_ready"}, 128'(key_if.ready), 128'd1);
        @(posedge clk);
        #1;
        key_if.valid = 1'b0;
    endtask

    task automatic waitValid(input string tag, output int n);
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            #1;
            if (keys_valid) break;
        end
        checkOutput({tag, "_kv_rise"}, 128'(keys_valid), 128'd1);
    endtask

    task automatic sweepKeys(input string tag);
        for (int i = 0; i < 11; i++) begin
            rd_idx = 4'(i);
            #1;
            checkOutput($sformatf("%s_rk%0d", tag, i), rd_key, model_rk[i]);
        end
        rd_idx = 4'd11;
        #1;
        checkOutput({tag, "_idx11"}, rd_key, 128'h0);
        rd_idx = 4'd15;
        #1;
        checkOutput({tag, "_idx15"}, rd_key, 128'h0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_kv"}, 128'(keys_valid), 128'd0);
        checkOutput({tag, "_busy"}, 128'(busy), 128'd0);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            #1;
            checkOutput($sformatf("%s_zero%0d", tag, i), rd_key, 128'h0);
        end
    endtask

    task automatic fullKey(input string tag, input logic [127:0] key);
        int n;
        buildModel(key);
        applyStimulus(tag, key);
        waitValid(tag, n);
        sweepKeys(tag);
    endtask

    initial begin
        int n;
        logic [127:0] k1, k2, k3;

        rst          = 1'b1;
        rd_idx       = 4'd0;
        key_if.data  = '0;
        key_if.valid = 1'b0;

        #12;
        checkCleared("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_ready", 128'(key_if.ready), 128'd1);

        // FIPS-197 Appendix A key, including the exact completion latency.
        buildModel(128'h2b7e151628aed2a6abf7158809cf4f3c);
        applyStimulus("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c);
        checkOutput("fips_busy", 128'(busy), 128'd1);
        checkOutput("fips_ready_exp", 128'(key_if.ready), 128'd0);
        waitValid("fips", n);
        checkOutput("fips_latency", 128'(n), 128'd10);
        checkOutput("fips_busy_done", 128'(busy), 128'd0);
        rd_idx = 4'd1;
        #1;
        checkOutput("fips_vec_rk1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10;
        #1;
        checkOutput("fips_vec_rk10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        sweepKeys("fips");

        fullKey("zero", 128'h0);
        rd_idx = 4'd1;
        #1;
        checkOutput("zero_vec_rk1", rd_key, 128'h62636363626363636263636362636363);
        rd_idx = 4'd10;
        #1;
        checkOutput("zero_vec_rk10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Valid offered mid-expansion must be ignored.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        buildModel(k1);
        applyStimulus("bp", k1);
        @(negedge clk);
        key_if.data  = k2;
        key_if.valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput($sformatf("bp_ready%0d", c), 128'(key_if.ready), 128'd0);
            @(negedge clk);
        end
        key_if.valid = 1'b0;
        waitValid("bp", n);
        sweepKeys("bp");

        // New key from DONE invalidates the old schedule at the handshake edge.
        k3 = {$urandom, $urandom, $urandom, $urandom};
        buildModel(k3);
        applyStimulus("redo", k3);
        checkOutput("redo_kv_drop", 128'(keys_valid), 128'd0);
        checkOutput("redo_busy", 128'(busy), 128'd1);
        waitValid("redo", n);
        checkOutput("redo_latency", 128'(n), 128'd10);
        sweepKeys("redo");

        // Reset just after the fifth expansion edge.
        applyStimulus("mid", {$urandom, $urandom, $urandom, $urandom});
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkCleared("midrst");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready", 128'(key_if.ready), 128'd1);
        fullKey("after_rst", {$urandom, $urandom, $urandom, $urandom});

        for (int r = 0; r < 3; r++) begin
            fullKey($sformatf("rand%0d", r), {$urandom, $urandom, $urandom, $urandom});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
Name: aes_key_expander

Overview:
- Upstream neighbour of the AES-128 encrypter. Accepts a 128-bit cipher key over a dvr_if handshake and expands it iteratively, one round key per clock, into the 11 FIPS-197 round keys.
- Holds the keys in an internal register file. The encrypter reads them by index, random access and combinational.
- Raises keys_valid once the full schedule is complete.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; only 10 (AES-128) supported, elaboration-time assertion otherwise.
- KEY_WIDTH, 128, key and round-key width in bits; fixed at 128, asserted.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- key_in  dvr_if.slave  data[KEY_WIDTH]  cipher key; key_in.data[127:120] = FIPS-197 byte 0.
- rd_idx  in  4  round-key index to read, 0..NUM_ROUNDS.
- rd_key  out  128  round key at rd_idx (combinational from the register file).
- keys_valid  out  1  high when all NUM_ROUNDS+1 keys are stored and consistent.
- busy  out  1  high while expansion is in progress.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, rcon = 8'h01, round counter = 0, register file all zeros.
  - keys_valid = 0, busy = 0, key_in.ready = 1 once rst deasserts.
- States:
  - IDLE: no key loaded since reset.
  - EXPAND: schedule generation in progress.
  - DONE: schedule complete.
- key_in.ready: = 1 in IDLE and DONE; = 0 in EXPAND, so a new key cannot be accepted mid-expansion.
- Key acceptance (key_in.valid && key_in.ready at edge E0):
  - rk[0] <= key_in.data; working words w0..w3 <= key_in.data (w0 = [127:96]).
  - counter <= 1, rcon <= 8'h01, state -> EXPAND.
  - keys_valid <= 0 at the same edge; this also covers acceptance from DONE, so stale keys are invalidated immediately.
- EXPAND, each edge Ek (k = 1..10):
  - temp = SubWord(RotWord(w3)) ^ {rcon, 24'h0}.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - rk[counter] <= {w0', w1', w2', w3'}; working words updated.
  - rcon <= xtime(rcon): shift left by 1, XOR 8'h1B if bit7 was set. Sequence is 01,02,04,08,10,20,40,80,1B,36.
  - counter++.
- Completion: at E10 (counter == NUM_ROUNDS), state -> DONE, keys_valid <= 1, busy <= 0.
  - keys_valid is visible in the cycle after E10, i.e. 10 clocks after the acceptance edge.
- busy = (state == EXPAND).
- Critical path: one word of 4 S-box lookups plus the XOR chain per cycle; no pipelining.
- rd_key reads:
  - rd_idx 0..10 returns the register contents in any state; during EXPAND, entries not yet written hold previous-key or zero values. Consumers must gate on keys_valid.
  - rd_idx 11..15 returns 128'h0.
- Simultaneous events: key_in.valid held high in DONE restarts expansion every time it is accepted. The upstream must drop valid after its handshake.
- Reset mid-EXPAND: everything returns to reset values, keys_valid = 0, and any partial schedule is discarded (register file cleared).

Decomposition:
- Shared package aes_pkg:
  - SBOX constant array [256] of byte.
  - NUM_ROUNDS_AES128 = 10, word_t (32 bit), round_key_t (128 bit).
  - expander_sm_t enum {IDLE, EXPAND, DONE} (2-bit encoding).
  - xtime() and sub_word() functions.
- One sub-module, aes_sbox: combinational byte in / byte out from the package table; 4 instances for SubWord.
- The same sub-module is reusable by the encrypter's SubBytes.

Test Plan:
- Reset: assert rst mid-cycle → keys_valid = 0, busy = 0, rd_key = 0 for all idx; after release, key_in.ready = 1.
- FIPS-197 App. A key 2b7e151628aed2a6abf7158809cf4f3c →
  - rk[1] = a0fafe1788542cb123a339392a6c7605.
  - rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - keys_valid rises exactly 10 clocks after the handshake edge.
- All-zero key →
  - rk[1] = 62636363626363636263636362636363.
  - rk[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- Back-pressure: drive key_in.valid during EXPAND → ready = 0, no acceptance, schedule unaffected. New key from DONE → keys_valid drops at the acceptance edge, and the new schedule is correct.
- Reset at E5 of expansion → all state cleared; a subsequent key yields a correct full schedule.
- rd_idx = 11 and 15 → rd_key = 0. rd_idx sweep 0..10 in DONE matches the reference model.
